// File: rtl/disp_scan_arbiter.sv
// disp_scan_arbiter: timing sequencer and fixed-priority display arbiter
// for a 4-digit multiplexed 7-segment scanner. It produces the scanner step
// pulse, tracks the 8-step scan frame, and at each frame end grants the
// display to one of three sources. It then latches a frame-coherent snapshot
// of that source's digits, with per-digit blinking while set-mode owns it.
`timescale 1ns/1ps
module disp_scan_arbiter #(
   parameter int unsigned SCAN_DIV     = 2500,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter int unsigned MIN_HOLD     = 4,
   parameter logic [7:0]  BLANK_PAT    = 8'h00
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  REQ,
   input  logic [31:0] D0,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   input  logic [3:0]  BLINK_MASK,
   output logic        ENABLE,
   output logic [7:0]  L1,
   output logic [7:0]  L2,
   output logic [7:0]  L3,
   output logic [7:0]  L4,
   output logic [2:0]  GNT,
   output logic        FRAME
);

   localparam logic [15:0] PRE_LAST   = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0]  HOLD_MIN   = 8'(MIN_HOLD);

   localparam logic [2:0]  G_IDLE  = 3'b000;
   localparam logic [2:0]  G_TIME  = 3'b001;
   localparam logic [2:0]  G_SET   = 3'b010;
   localparam logic [2:0]  G_ALARM = 3'b100;

   // Priority rank of a one-hot grant; idle ranks lowest.
   function automatic logic [1:0] f_level(input logic [2:0] onehot);
      logic [1:0] lvl;
      case (onehot)
         G_ALARM: lvl = 2'd3;
         G_SET:   lvl = 2'd2;
         G_TIME:  lvl = 2'd1;
         default: lvl = 2'd0;
      endcase
      return lvl;
   endfunction

   // Highest-priority requester as a one-hot code, or idle.
   function automatic logic [2:0] f_pick(input logic [2:0] req);
      logic [2:0] pick;
      if (req[2]) begin
         pick = G_ALARM;
      end else if (req[1]) begin
         pick = G_SET;
      end else if (req[0]) begin
         pick = G_TIME;
      end else begin
         pick = G_IDLE;
      end
      return pick;
   endfunction

   logic [15:0] r_pre_cnt;
   logic        r_enable;
   logic [2:0]  r_ph;
   logic        r_frame;
   logic [2:0]  r_gnt;
   logic [7:0]  r_hold_cnt;
   logic [7:0]  r_blink_cnt;
   logic        r_blink_ph;
   logic [31:0] r_l;

   logic        w_frame_end;
   logic [2:0]  w_cand;
   logic        w_switch;
   logic [2:0]  w_gnt_nxt;
   logic [7:0]  w_hold_nxt;
   logic [7:0]  w_blink_cnt_nxt;
   logic        w_blink_ph_nxt;
   logic [31:0] w_l_nxt;

   assign w_frame_end = r_enable && (r_ph == 3'd7);

   // Prescaler: one registered ENABLE pulse every SCAN_DIV cycles.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pre_cnt <= 16'd0;
         r_enable  <= 1'b0;
      end else begin
         if (r_pre_cnt == PRE_LAST) begin
            r_pre_cnt <= 16'd0;
         end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
         end
         r_enable <= (r_pre_cnt == PRE_LAST);
      end
   end

   // Scan phase tracker mirroring the scanner's 8-step cycle; FRAME trails frame end.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ph    <= 3'd0;
         r_frame <= 1'b0;
      end else begin
         if (r_enable) begin
            r_ph <= r_ph + 3'd1;
         end else begin
            r_ph <= r_ph;
         end
         r_frame <= w_frame_end;
      end
   end

   // Ownership state register plus hold, blink and snapshot registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_gnt       <= G_IDLE;
         r_hold_cnt  <= 8'd0;
         r_blink_cnt <= 8'd0;
         r_blink_ph  <= 1'b0;
         r_l         <= {4{BLANK_PAT}};
      end else begin
         r_gnt       <= w_gnt_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
         r_blink_ph  <= w_blink_ph_nxt;
         r_l         <= w_l_nxt;
      end
   end

   // Next owner: pre-empt on higher priority, otherwise move only once hold is met.
   always_comb begin
      w_cand     = f_pick(REQ);
      w_switch   = 1'b0;
      w_gnt_nxt  = r_gnt;
      w_hold_nxt = r_hold_cnt;
      if (w_frame_end) begin
         if (f_level(w_cand) > f_level(r_gnt)) begin
            w_switch = 1'b1;
         end else if ((w_cand != r_gnt) && (r_hold_cnt >= HOLD_MIN)) begin
            w_switch = 1'b1;
         end else begin
            w_switch = 1'b0;
         end
         if (w_switch) begin
            w_gnt_nxt  = w_cand;
            w_hold_nxt = 8'd1;
         end else if (r_hold_cnt != 8'hFF) begin
            w_hold_nxt = r_hold_cnt + 8'd1;
         end else begin
            w_hold_nxt = r_hold_cnt;
         end
      end else begin
         w_gnt_nxt  = r_gnt;
         w_hold_nxt = r_hold_cnt;
      end
   end

   // Blink phase and digit snapshot for the owner chosen at this frame end.
   always_comb begin
      w_blink_cnt_nxt = r_blink_cnt;
      w_blink_ph_nxt  = r_blink_ph;
      w_l_nxt         = r_l;
      if (w_frame_end) begin
         case (w_gnt_nxt)
            G_SET: begin
               if (w_switch) begin
                  w_blink_cnt_nxt = 8'd0;
                  w_blink_ph_nxt  = 1'b0;
               end else if (r_blink_cnt == BLINK_LAST) begin
                  w_blink_cnt_nxt = 8'd0;
                  w_blink_ph_nxt  = ~r_blink_ph;
               end else begin
                  w_blink_cnt_nxt = r_blink_cnt + 8'd1;
                  w_blink_ph_nxt  = r_blink_ph;
               end
            end
            default: begin
               w_blink_cnt_nxt = 8'd0;
               w_blink_ph_nxt  = 1'b0;
            end
         endcase
         case (w_gnt_nxt)
            G_ALARM: w_l_nxt = D2;
            G_TIME:  w_l_nxt = D0;
            G_SET: begin
               for (int k = 0; k < 4; k++) begin
                  if (w_blink_ph_nxt && BLINK_MASK[k]) begin
                     w_l_nxt[8*k +: 8] = BLANK_PAT;
                  end else begin
                     w_l_nxt[8*k +: 8] = D1[8*k +: 8];
                  end
               end
            end
            default: w_l_nxt = {4{BLANK_PAT}};
         endcase
      end else begin
         w_blink_cnt_nxt = r_blink_cnt;
         w_blink_ph_nxt  = r_blink_ph;
         w_l_nxt         = r_l;
      end
   end

   assign ENABLE = r_enable;
   assign FRAME  = r_frame;
   assign GNT    = r_gnt;
   assign L1     = r_l[7:0];
   assign L2     = r_l[15:8];
   assign L3     = r_l[23:16];
   assign L4     = r_l[31:24];

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Scoreboard bench for disp_scan_arbiter. A reference model pushes the
// expected owner/digits at every frame end; a monitor pops an entry on each
// FRAME pulse and checks GNT and L1..L4 on every cycle against it.
`timescale 1ns/1ps
module tb_disp_scan_arbiter;

   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int MIN_HOLD     = 2;
   localparam logic [7:0] BLANK = 8'h00;
   localparam int FRAME_LEN    = SCAN_DIV * 8;

   logic        CLK;
   logic        RESET;
   logic [2:0]  REQ;
   logic [31:0] D0, D1, D2;
   logic [3:0]  BLINK_MASK;
   logic        ENABLE, FRAME;
   logic [7:0]  L1, L2, L3, L4;
   logic [2:0]  GNT;

   typedef struct packed {
      logic [2:0]  gnt;
      logic [31:0] l;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_push = 0;
   int   n_pop  = 0;
   int   cyc    = 0;

   disp_scan_arbiter #(
      .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES),
      .MIN_HOLD(MIN_HOLD), .BLANK_PAT(BLANK)
   ) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .D0(D0), .D1(D1), .D2(D2),
      .BLINK_MASK(BLINK_MASK), .ENABLE(ENABLE), .L1(L1), .L2(L2), .L3(L3),
      .L4(L4), .GNT(GNT), .FRAME(FRAME)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Reference model: owner as a rank 0..3, hold in frames, age of the current grant.
   initial begin
      int   m_own, m_hold, m_age, cand;
      exp_t e;
      m_own = 0; m_hold = 0; m_age = 0;
      forever begin
         @(posedge CLK);
         if (RESET) begin
            cyc = 0; m_own = 0; m_hold = 0; m_age = 0;
            sb_q.delete();
         end else begin
            cyc++;
            if (cyc > FRAME_LEN && (cyc % FRAME_LEN) == 1) begin
               cand = REQ[2] ? 3 : (REQ[1] ? 2 : (REQ[0] ? 1 : 0));
               if (cand > m_own || (cand != m_own && m_hold >= MIN_HOLD)) begin
                  m_own = cand; m_hold = 1; m_age = 1;
               end else begin
                  m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
                  m_age++;
               end
               e.gnt = (m_own == 0) ? 3'b000 : 3'(1 << (m_own - 1));
               case (m_own)
                  3: e.l = D2;
                  1: e.l = D0;
                  2: begin
                     e.l = D1;
                     if ((((m_age - 1) / BLINK_FRAMES) % 2) == 1) begin
                        for (int k = 0; k < 4; k++) begin
                           if (BLINK_MASK[k]) e.l[8*k +: 8] = BLANK;
                        end
                     end
                  end
                  default: e.l = {4{BLANK}};
               endcase
               sb_q.push_back(e);
               n_push++;
            end
         end
      end
   end

   // Monitor: timing of ENABLE/FRAME, pop on FRAME, outputs held between frames.
   initial begin
      exp_t cur;
      cur.gnt = 3'b000;
      cur.l   = {4{BLANK}};
      forever begin
         @(negedge CLK);
         if (RESET) begin
            cur.gnt = 3'b000;
            cur.l   = {4{BLANK}};
            check("rst_enable", 32'(ENABLE), 32'd0);
            check("rst_frame",  32'(FRAME),  32'd0);
            check("rst_gnt",    32'(GNT),    32'd0);
            check("rst_l",      {L4, L3, L2, L1}, {4{BLANK}});
         end else begin
            check("enable", 32'(ENABLE), 32'((cyc >= SCAN_DIV) && (cyc % SCAN_DIV == 0)));
            check("frame",  32'(FRAME),  32'((cyc > FRAME_LEN) && (cyc % FRAME_LEN == 1)));
            if (FRAME) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_empty: FRAME seen with no expected entry at %0t", $time);
               end else begin
                  cur = sb_q.pop_front();
                  n_pop++;
               end
            end
            check("gnt", 32'(GNT), 32'(cur.gnt));
            check("l",   {L4, L3, L2, L1}, cur.l);
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      RESET = 1'b1; REQ = 3'b000; D0 = 32'd0; D1 = 32'd0; D2 = 32'd0; BLINK_MASK = 4'd0;
      step(3);
      RESET = 1'b0;
      step(2 * FRAME_LEN);                              // idle frames
      REQ = 3'b001; D0 = 32'h11223344;
      step(FRAME_LEN + 10);
      D0 = 32'h55667788;                                // mid-frame data change
      step(FRAME_LEN);
      D2 = 32'h99AABBCC; REQ = 3'b101;                  // alarm pre-empts time
      step(FRAME_LEN);
      REQ = 3'b001;                                     // hold keeps alarm one more frame
      step(3 * FRAME_LEN);
      D1 = 32'hAABBCCDD; BLINK_MASK = 4'b0011; REQ = 3'b010;
      step(6 * FRAME_LEN);                              // blink pattern
      REQ = 3'b100;
      step(2 * FRAME_LEN + 13);
      @(posedge CLK);
      #2 RESET = 1'b1;                                  // async reset mid-frame
      #1;
      check("async_gnt",    32'(GNT),    32'd0);
      check("async_l",      {L4, L3, L2, L1}, {4{BLANK}});
      check("async_enable", 32'(ENABLE), 32'd0);
      step(2);
      RESET = 1'b0;
      step(2 * FRAME_LEN);
      for (int f = 0; f < 40; f++) begin
         for (int s = 0; s < 4; s++) begin
            REQ = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) D0 = $urandom;
            if ($urandom_range(0, 3) == 0) D1 = $urandom;
            if ($urandom_range(0, 3) == 0) D2 = $urandom;
            BLINK_MASK = 4'($urandom_range(0, 15));
            step($urandom_range(1, 16));
         end
      end
      step(FRAME_LEN + 2);
      check("sb_drain", 32'(n_pop), 32'(n_push));
      check("sb_left",  32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
